// File: rtl/pattern_session_ctrl.sv
// Session controller for the UART 4-bit pattern-detection datapath: accepts a host
// command, clears and arms the datapath, counts status pulses and reports termination.
module pattern_session_ctrl #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned ERR_LIMIT      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_pattern,
    input  logic [CNT_W-1:0] cmd_target,
    input  logic [CNT_W-1:0] cmd_frames,
    input  logic             cmd_abort,
    input  logic             bit_strobe,
    input  logic             match_pulse,
    input  logic             frame_done,
    input  logic             framing_error,
    output logic [3:0]       dp_pattern,
    output logic             dp_clear,
    output logic             dp_enable,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ARMED, S_REPORT} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_status, w_status_nxt;
    logic [3:0]       r_pattern;
    logic [CNT_W-1:0] r_target, r_budget, r_match, r_frame, r_err;
    logic [TO_W-1:0]  r_to;
    logic             r_cmd_ready, r_dp_clear, r_dp_enable, r_busy, r_done;

    logic [CNT_W-1:0] w_match_nxt, w_frame_nxt, w_err_nxt;
    logic [TO_W-1:0]  w_to_nxt;
    logic             w_accept, w_hit_target, w_hit_err, w_hit_budget, w_hit_to;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Post-increment values; termination is judged on these, so coincident pulses count
    assign w_accept     = (r_state == S_IDLE) && cmd_valid;
    assign w_match_nxt  = sat_inc(r_match, match_pulse);
    assign w_frame_nxt  = sat_inc(r_frame, frame_done);
    assign w_err_nxt    = sat_inc(r_err, framing_error);
    assign w_to_nxt     = bit_strobe ? '0 : ((r_to == '1) ? r_to : r_to + TO_W'(1));
    assign w_hit_target = (r_target != '0) && (w_match_nxt >= r_target);
    assign w_hit_err    = (ERR_LIMIT != 0) && (w_err_nxt >= CNT_W'(ERR_LIMIT));
    assign w_hit_budget = (r_budget != '0) && (w_frame_nxt >= r_budget);
    assign w_hit_to     = (TIMEOUT_CYCLES != 0) && (w_to_nxt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_status <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt  = S_CLEAR;
                    w_status_nxt = 2'b00;
                end
            end
            S_CLEAR: begin
                if (cmd_abort) begin
                    w_state_nxt  = S_REPORT;
                    w_status_nxt = 2'b10;
                end else begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_hit_target) begin
                    w_state_nxt  = S_REPORT;
                    w_status_nxt = 2'b00;
                end else if (cmd_abort || w_hit_err) begin
                    w_state_nxt  = S_REPORT;
                    w_status_nxt = 2'b10;
                end else if (w_hit_budget) begin
                    w_state_nxt  = S_REPORT;
                    w_status_nxt = 2'b01;
                end else if (w_hit_to) begin
                    w_state_nxt  = S_REPORT;
                    w_status_nxt = 2'b11;
                end
            end
            S_REPORT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch and session counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= '0;
            r_target  <= '0;
            r_budget  <= '0;
            r_match   <= '0;
            r_frame   <= '0;
            r_err     <= '0;
            r_to      <= '0;
        end else if (w_accept) begin
            r_pattern <= cmd_pattern;
            r_target  <= cmd_target;
            r_budget  <= cmd_frames;
            r_match   <= '0;
            r_frame   <= '0;
            r_err     <= '0;
            r_to      <= '0;
        end else if (r_state == S_ARMED) begin
            r_match <= w_match_nxt;
            r_frame <= w_frame_nxt;
            r_err   <= w_err_nxt;
            r_to    <= w_to_nxt;
        end
    end

    // Handshake and datapath controls registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b1;
            r_dp_clear  <= 1'b0;
            r_dp_enable <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_dp_clear  <= (w_state_nxt == S_CLEAR);
            r_dp_enable <= (w_state_nxt == S_ARMED);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_REPORT);
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign dp_pattern  = r_pattern;
    assign dp_clear    = r_dp_clear;
    assign dp_enable   = r_dp_enable;
    assign busy        = r_busy;
    assign done        = r_done;
    assign status      = r_status;
    assign match_count = r_match;
    assign frame_count = r_frame;
    assign err_count   = r_err;

endmodule

// File: tb/tb_pattern_session_ctrl.sv
// Self-checking bench for pattern_session_ctrl: session table, hand-written corner
// sequences and random traffic, all compared each cycle against a session-level model.
module tb_pattern_session_ctrl;

    localparam int unsigned CNT_W          = 8;
    localparam int unsigned ERR_LIMIT      = 2;
    localparam int unsigned TIMEOUT_CYCLES = 64;
    localparam int unsigned TO_W           = 16;
    localparam int          MAXC           = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_abort;
    logic [3:0]       cmd_pattern, dp_pattern;
    logic [CNT_W-1:0] cmd_target, cmd_frames;
    logic             bit_strobe, match_pulse, frame_done, framing_error;
    logic             dp_clear, dp_enable, busy, done;
    logic [1:0]       status;
    logic [CNT_W-1:0] match_count, frame_count, err_count;

    always #5 clk = ~clk;

    pattern_session_ctrl #(
        .CNT_W(CNT_W), .ERR_LIMIT(ERR_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pattern(cmd_pattern),
        .cmd_target(cmd_target), .cmd_frames(cmd_frames), .cmd_abort(cmd_abort),
        .bit_strobe(bit_strobe), .match_pulse(match_pulse), .frame_done(frame_done),
        .framing_error(framing_error),
        .dp_pattern(dp_pattern), .dp_clear(dp_clear), .dp_enable(dp_enable),
        .busy(busy), .done(done), .status(status),
        .match_count(match_count), .frame_count(frame_count), .err_count(err_count)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // Session-level reference: active flag, age since accept, and whether this is the report cycle
    int m_active, m_age, m_report, m_pat, m_tgt, m_bud, m_mc, m_fc, m_ec, m_idle, m_status;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        m_active = 0; m_age = 0; m_report = 0; m_pat = 0; m_tgt = 0; m_bud = 0;
        m_mc = 0; m_fc = 0; m_ec = 0; m_idle = 0; m_status = 0;
    endtask

    function automatic int sat(int v);
        return (v < MAXC) ? v + 1 : MAXC;
    endfunction

    task automatic end_session(int st);
        m_report = 1;
        m_status = st;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        if (!m_active) begin
            if (cmd_valid) begin
                m_active = 1; m_age = 1; m_report = 0;
                m_pat = int'(cmd_pattern); m_tgt = int'(cmd_target); m_bud = int'(cmd_frames);
                m_mc = 0; m_fc = 0; m_ec = 0; m_idle = 0; m_status = 0;
            end
        end else if (m_report) begin
            m_active = 0; m_report = 0;
        end else if (m_age == 1) begin
            if (cmd_abort) end_session(2);
            m_age = 2;
        end else begin
            if (match_pulse)   m_mc = sat(m_mc);
            if (frame_done)    m_fc = sat(m_fc);
            if (framing_error) m_ec = sat(m_ec);
            m_idle = bit_strobe ? 0 : m_idle + 1;
            if (m_tgt != 0 && m_mc >= m_tgt)                  end_session(0);
            else if (cmd_abort)                               end_session(2);
            else if (ERR_LIMIT != 0 && m_ec >= ERR_LIMIT)     end_session(2);
            else if (m_bud != 0 && m_fc >= m_bud)             end_session(1);
            else if (TIMEOUT_CYCLES != 0 && m_idle == TIMEOUT_CYCLES) end_session(3);
            m_age++;
        end
    endtask

    task automatic check_outputs();
        chk("cmd_ready",   cmd_ready,   (m_active == 0) ? 1 : 0);
        chk("busy",        busy,        m_active);
        chk("dp_clear",    dp_clear,    (m_active != 0 && m_age == 1 && m_report == 0) ? 1 : 0);
        chk("dp_enable",   dp_enable,   (m_active != 0 && m_age >= 2 && m_report == 0) ? 1 : 0);
        chk("done",        done,        m_report);
        chk("dp_pattern",  dp_pattern,  m_pat);
        chk("status",      status,      m_status);
        chk("match_count", match_count, m_mc);
        chk("frame_count", frame_count, m_fc);
        chk("err_count",   err_count,   m_ec);
    endtask

    task automatic clear_inputs();
        cmd_valid = 0; cmd_abort = 0; bit_strobe = 0;
        match_pulse = 0; frame_done = 0; framing_error = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
        clear_inputs();
    endtask

    // Present a command and hold it until accepted (bounded)
    task automatic issue(input int pat, input int tgt, input int bud);
        bit acc;
        acc = 0;
        for (int i = 0; i < 12 && !acc; i++) begin
            cmd_valid = 1; cmd_pattern = 4'(pat);
            cmd_target = CNT_W'(tgt); cmd_frames = CNT_W'(bud);
            acc = cmd_ready;
            step();
        end
        chk("accept_within_bound", acc, 1);
    endtask

    typedef struct {
        int pat, tgt, bud;
        int n_match, n_plain, n_errf;
        bit match_err;
        int abort_after;
        int exp_status, exp_mc, exp_fc, exp_ec;
    } sess_t;

    sess_t tbl[7];

    task automatic run_session(input sess_t s);
        int nf, n_done;
        bit got;
        nf = s.n_match + s.n_plain + s.n_errf;
        n_done = 0; got = 0;
        issue(s.pat, s.tgt, s.bud);
        for (int f = 0; f <= nf && !got; f++) begin
            if (f == s.abort_after) begin
                cmd_abort = 1; step();
                if (done) begin got = 1; n_done++; end
            end
            if (f == nf || got) break;
            for (int g = 0; g < 4 && !got; g++) begin
                bit_strobe = 1;
                if (g == 3) begin
                    if (f < s.n_match) begin
                        match_pulse = 1; frame_done = 1; framing_error = s.match_err;
                    end else if (f < s.n_match + s.n_plain) begin
                        frame_done = 1;
                    end else begin
                        framing_error = 1;
                    end
                end
                step();
                if (done) begin got = 1; n_done++; end
            end
        end
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (done) begin got = 1; n_done++; end
        end
        chk("session_done_seen", got, 1);
        chk("session_status", status, s.exp_status);
        chk("session_match",  match_count, s.exp_mc);
        chk("session_frames", frame_count, s.exp_fc);
        chk("session_errs",   err_count, s.exp_ec);
        chk("session_pattern", dp_pattern, s.pat);
        for (int i = 0; i < 2; i++) begin
            step();
            if (done) n_done++;
        end
        chk("session_one_done", n_done, 1);
    endtask

    initial begin
        int a_cyc, d_cyc;
        // pat tgt bud  nm np ne merr abort  st mc fc ec
        tbl[0] = '{6, 3, 0,  3, 0, 0, 0, -1,  0, 3, 3, 0};
        tbl[1] = '{2, 0, 4,  0, 4, 0, 0, -1,  1, 0, 4, 0};
        tbl[2] = '{5, 0, 0,  0, 0, 2, 0, -1,  2, 0, 0, 2};
        tbl[3] = '{9, 2, 0,  2, 0, 0, 1, -1,  0, 2, 2, 2};
        tbl[4] = '{1, 5, 2,  2, 0, 0, 0, -1,  1, 2, 2, 0};
        tbl[5] = '{7, 0, 0,  0, 1, 0, 0,  1,  2, 0, 1, 0};
        tbl[6] = '{3, 1, 1,  1, 0, 0, 0, -1,  0, 1, 1, 0};

        rst_n = 0;
        clear_inputs();
        cmd_pattern = 0; cmd_target = 0; cmd_frames = 0;
        model_reset();
        #12;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pattern", dp_pattern, 0);
        check_outputs();
        rst_n = 1;

        foreach (tbl[i]) run_session(tbl[i]);

        // Abort while clearing: abort is ignored at the accept edge, seen in the clear cycle
        cmd_abort = 1;
        issue(4, 3, 3);
        chk("abort_clear_dp_clear", dp_clear, 1);
        cmd_abort = 1; step();
        chk("abort_clear_done", done, 1);
        chk("abort_clear_status", status, 2);
        chk("abort_clear_frames", frame_count, 0);
        step(); step();

        // Timeout with no traffic: armed at cycle A, expire 64 armed clocks later
        issue(8, 0, 0);
        step();
        chk("to_armed", dp_enable, 1);
        a_cyc = cyc; d_cyc = -1;
        for (int i = 0; i < 200 && d_cyc < 0; i++) begin step(); if (done) d_cyc = cyc; end
        chk("to_done_cycle", d_cyc - a_cyc, 64);
        chk("to_status", status, 3);
        step(); step();

        // A strobe at armed cycle 40 restarts the count from zero at that edge
        issue(8, 0, 0);
        step();
        a_cyc = cyc; d_cyc = -1;
        for (int i = 0; i < 300 && d_cyc < 0; i++) begin
            if (cyc - a_cyc == 40) bit_strobe = 1;
            step();
            if (done) d_cyc = cyc;
        end
        chk("to_strobe_done_cycle", d_cyc - a_cyc, 40 + 1 + 64);
        chk("to_strobe_status", status, 3);
        step(); step();

        // Command held during an armed session is only taken once back in IDLE
        issue(2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1; cmd_pattern = 4'd3; bit_strobe = 1; step();
            chk("held_not_ready", cmd_ready, 0);
        end
        cmd_valid = 1; cmd_pattern = 4'd3; cmd_abort = 1; step();
        chk("held_abort_done", done, 1);
        chk("held_pattern_kept", dp_pattern, 2);
        cmd_valid = 1; step();
        chk("held_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_target = 0; cmd_frames = 0; step();
        chk("held_accepted_clear", dp_clear, 1);
        chk("held_new_pattern", dp_pattern, 3);
        cmd_abort = 1; step(); step(); step();

        // Reset mid-armed with counters 2/1/0
        issue(6, 0, 0);
        bit_strobe = 1; step();
        match_pulse = 1; frame_done = 1; bit_strobe = 1; step();
        match_pulse = 1; bit_strobe = 1; step();
        chk("pre_reset_match", match_count, 2);
        chk("pre_reset_frames", frame_count, 1);
        rst_n = 0;
        #1;
        model_reset();
        chk("mid_reset_cmd_ready", cmd_ready, 1);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_match", match_count, 0);
        chk("mid_reset_pattern", dp_pattern, 0);
        check_outputs();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin step(); chk("post_reset_no_done", done, 0); end

        // Saturation: 300 frames with unlimited budget
        issue(1, 0, 0);
        for (int i = 0; i < 300; i++) begin frame_done = 1; bit_strobe = 1; step(); end
        chk("sat_frames", frame_count, MAXC);
        cmd_abort = 1; step(); step(); step();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cmd_valid     = ($urandom_range(0, 2) == 0);
            cmd_pattern   = 4'($urandom_range(0, 9));
            cmd_target    = CNT_W'($urandom_range(0, 4));
            cmd_frames    = CNT_W'($urandom_range(0, 6));
            cmd_abort     = ($urandom_range(0, 39) == 0);
            bit_strobe    = ($urandom_range(0, 2) == 0);
            match_pulse   = ($urandom_range(0, 5) == 0);
            frame_done    = ($urandom_range(0, 4) == 0);
            framing_error = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
